sha256_schedule_stream: RTL and testbench

//  Folded, parametrised SHA-256 message scheduler (FIPS 180-4 sec. 6.2.2.1).
//  - Accepts one 512-bit block over a valid/ready handshake.
//  - Streams K[t]+W[t] for t=0..63, LANES words per beat, with output backpressure.
//  - Feeds a folded compression core. Replaces the unrolled 16-stage quad pipeline

---
 rtl/sha256_pkg.sv | 52 +++++
 rtl/sha256_sched_word.sv | 18 +
 rtl/sha256_schedule_stream.sv | 110 +++++++++++
 tb/tb_sha256_schedule_stream.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 schedule definitions: word width, round constants,
// the controller state type and the small-sigma helper functions.
package sha256_pkg;

    localparam int WORDBITS = 32;
    localparam int KROUNDS  = 64;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_t;

    localparam logic [31:0] K [KROUNDS] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] shr(input logic [31:0] x, input int n);
        return x >> n;
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ shr(x, 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ shr(x, 10);
    endfunction

    function automatic logic [31:0] k_at(input logic [5:0] idx);
        return K[idx];
    endfunction

endpackage

// File: rtl/sha256_sched_word.sv
// One message-schedule recurrence step:
// W[t] = sig1(W[t-2]) + W[t-7] + sig0(W[t-15]) + W[t-16], modulo 2^32.
module sha256_sched_word
    import sha256_pkg::*;
(
    input  logic [WORDBITS-1:0] w_m16,
    input  logic [WORDBITS-1:0] w_m15,
    input  logic [WORDBITS-1:0] w_m7,
    input  logic [WORDBITS-1:0] w_m2,
    output logic [WORDBITS-1:0] w_new
);

    // Two sigmas feeding a four-input modular add
    always_comb begin
        w_new = sig1(w_m2) + w_m7 + sig0(w_m15) + w_m16;
    end

endmodule

// File: rtl/sha256_schedule_stream.sv
// Folded SHA-256 message scheduler. Loads a 512-bit block, then streams
// K[t]+W[t] LANES words per beat. Handshakes: a transfer happens on a
// cycle where valid and ready are both high; valid never depends on ready,
// and a raised valid keeps its data stable until the transfer.
module sha256_schedule_stream
    import sha256_pkg::*;
#(
    parameter int WORDBITS  = sha256_pkg::WORDBITS,
    parameter int MSGWORDS  = 16,
    parameter int ROUNDS    = 64,
    parameter int LANES     = 4,
    parameter int PIPE_LOAD = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          blk_valid_in,
    output logic                          blk_ready_out,
    input  logic [MSGWORDS*WORDBITS-1:0]  W_in,
    output logic                          kw_valid_out,
    input  logic                          kw_ready_in,
    output logic [LANES*WORDBITS-1:0]     KW_out,
    output logic [$clog2(ROUNDS)-1:0]     round_out,
    output logic                          last_out
);

    localparam int TW = $clog2(ROUNDS);
    localparam int WW = MSGWORDS * WORDBITS;

    sched_state_t    state_q, state_d;
    logic [TW-1:0]   t_q, t_d;
    logic [WW-1:0]   win_q, win_d;
    logic [WW-1:0]   win_shift;
    logic            final_beat;
    logic            beat;
    logic            load;

    // Each lane sees the window advanced by its lane index, so new words
    // produced by lower lanes feed the higher lanes in the same beat.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [WW-1:0]       view_w;
        logic [WW-1:0]       next_w;
        logic [WORDBITS-1:0] n_w;

        if (j == 0) begin : g_first
            assign view_w = win_q;
        end else begin : g_chain
            assign view_w = g_lane[j-1].next_w;
        end

        sha256_sched_word u_word (
            .w_m16 (view_w[0 +: WORDBITS]),
            .w_m15 (view_w[WORDBITS +: WORDBITS]),
            .w_m7  (view_w[(MSGWORDS-7)*WORDBITS +: WORDBITS]),
            .w_m2  (view_w[(MSGWORDS-2)*WORDBITS +: WORDBITS]),
            .w_new (n_w)
        );

        assign next_w = {n_w, view_w[WW-1:WORDBITS]};

        // Lane output adds the round constant for t+j to the current window word
        assign KW_out[j*WORDBITS +: WORDBITS] =
            k_at(6'(t_q) + 6'(j)) + win_q[j*WORDBITS +: WORDBITS];
    end

    assign win_shift = g_lane[LANES-1].next_w;

    assign final_beat    = (t_q == TW'(ROUNDS - LANES));
    assign kw_valid_out  = (state_q == ST_RUN);
    assign round_out     = t_q;
    assign last_out      = kw_valid_out & final_beat;
    assign blk_ready_out = (state_q == ST_IDLE) |
                           ((PIPE_LOAD != 0) & kw_valid_out & final_beat & kw_ready_in);
    assign beat          = kw_valid_out & kw_ready_in;
    assign load          = blk_valid_in & blk_ready_out;

    // Next state: beats advance the window; a load overrides (pipelined reload)
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        win_d   = win_q;
        if (beat) begin
            win_d = win_shift;
            if (final_beat) begin
                state_d = ST_IDLE;
                t_d     = '0;
            end else begin
                t_d = t_q + TW'(LANES);
            end
        end
        if (load) begin
            win_d   = W_in;
            t_d     = '0;
            state_d = ST_RUN;
        end
    end

    // Controller, round counter and window registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            win_q   <= win_d;
        end
    end

endmodule

// File: tb/tb_sha256_schedule_stream.sv
module tb_sha256_schedule_stream;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [511:0] w_in = '0;

  // main instance: LANES=4, PIPE_LOAD=0
  logic         blk_valid_a = 1'b0, kw_ready_a = 1'b0;
  logic         blk_ready_a, kw_valid_a, last_a;
  logic [127:0] kw_a;
  logic [5:0]   round_a;

  // pipelined-load instance: LANES=4, PIPE_LOAD=1
  logic         blk_valid_p = 1'b0, kw_ready_p = 1'b0;
  logic         blk_ready_p, kw_valid_p, last_p;
  logic [127:0] kw_p;
  logic [5:0]   round_p;

  // lane-width variants share one handshake driver
  logic         blk_valid_v = 1'b0, kw_ready_v = 1'b0;
  logic         blk_ready_1, kw_valid_1, last_1;
  logic         blk_ready_2, kw_valid_2, last_2;
  logic         blk_ready_8, kw_valid_8, last_8;
  logic [31:0]  kw_1;
  logic [63:0]  kw_2;
  logic [255:0] kw_8;
  logic [5:0]   round_1, round_2, round_8;

  sha256_schedule_stream #(.LANES(4), .PIPE_LOAD(0)) dut (
    .clk(clk), .rst(rst), .blk_valid_in(blk_valid_a), .blk_ready_out(blk_ready_a), .W_in(w_in),
    .kw_valid_out(kw_valid_a), .kw_ready_in(kw_ready_a), .KW_out(kw_a), .round_out(round_a), .last_out(last_a));

  sha256_schedule_stream #(.LANES(4), .PIPE_LOAD(1)) dut_p (
    .clk(clk), .rst(rst), .blk_valid_in(blk_valid_p), .blk_ready_out(blk_ready_p), .W_in(w_in),
    .kw_valid_out(kw_valid_p), .kw_ready_in(kw_ready_p), .KW_out(kw_p), .round_out(round_p), .last_out(last_p));

  sha256_schedule_stream #(.LANES(1)) dut_l1 (
    .clk(clk), .rst(rst), .blk_valid_in(blk_valid_v), .blk_ready_out(blk_ready_1), .W_in(w_in),
    .kw_valid_out(kw_valid_1), .kw_ready_in(kw_ready_v), .KW_out(kw_1), .round_out(round_1), .last_out(last_1));

  sha256_schedule_stream #(.LANES(2)) dut_l2 (
    .clk(clk), .rst(rst), .blk_valid_in(blk_valid_v), .blk_ready_out(blk_ready_2), .W_in(w_in),
    .kw_valid_out(kw_valid_2), .kw_ready_in(kw_ready_v), .KW_out(kw_2), .round_out(round_2), .last_out(last_2));

  sha256_schedule_stream #(.LANES(8)) dut_l8 (
    .clk(clk), .rst(rst), .blk_valid_in(blk_valid_v), .blk_ready_out(blk_ready_8), .W_in(w_in),
    .kw_valid_out(kw_valid_8), .kw_ready_in(kw_ready_v), .KW_out(kw_8), .round_out(round_8), .last_out(last_8));

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_kw [2][64];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // reference model: straightforward FIPS schedule expansion
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x};
    return d[n +: 32];
  endfunction

  task automatic make_ref(input logic [511:0] blk, input int slot);
    logic [31:0] w [64];
    logic [31:0] s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[i*32 +: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int i = 0; i < 64; i++) ref_kw[slot][i] = KT[i] + w[i];
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // drive one block through the main instance; stop_at >= 0 leaves it mid-run
  task automatic run_a(input logic [511:0] blk, input bit rnd, input bit abc, input int stop_at);
    int nxt, cyc, beats, lasts;
    make_ref(blk, 0);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(ref_kw[0][i]);
    chk("a_ready_idle", 64'(blk_ready_a), 64'd1);
    w_in = blk;
    blk_valid_a = 1'b1;
    kw_ready_a = 1'b0;
    step();
    blk_valid_a = 1'b0;
    nxt = 0; cyc = 0; beats = 0; lasts = 0;
    while (nxt < 64 && cyc < 400) begin
      if (stop_at >= 0 && nxt == stop_at) return;
      kw_ready_a = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("a_valid", 64'(kw_valid_a), 64'd1);
      chk("a_round", 64'(round_a), 64'(nxt));
      chk("a_last", 64'(last_a), 64'(nxt == 60));
      chk("a_ready_run", 64'(blk_ready_a), 64'd0);
      for (int j = 0; j < 4; j++) chk("a_kw", 64'(kw_a[j*32 +: 32]), 64'(exp_q[j]));
      if (abc && nxt == 0) chk("abc_beat0", 64'(kw_a[31:0]), 64'hA3EC9318);
      if (abc && nxt == 16) begin
        chk("abc_t16", 64'(kw_a[31:0]), 64'h45FDCD41);
        chk("abc_w17", 64'(kw_a[63:32] - KT[17]), 64'h000F0000);
      end
      if (kw_ready_a) begin
        for (int j = 0; j < 4; j++) void'(exp_q.pop_front());
        if (last_a) lasts++;
        beats++;
        nxt += 4;
      end
      step();
      cyc++;
    end
    kw_ready_a = 1'b0;
    chk("a_done", 64'(nxt), 64'd64);
    chk("a_beats", 64'(beats), 64'd16);
    chk("a_last_count", 64'(lasts), 64'd1);
    chk("a_bubble_valid", 64'(kw_valid_a), 64'd0);
    chk("a_bubble_ready", 64'(blk_ready_a), 64'd1);
  endtask

  // stream one block through the lane-width variants
  task automatic run_variants(input logic [511:0] blk, input bit rnd);
    int c1, c2, c8, cyc;
    make_ref(blk, 0);
    w_in = blk;
    blk_valid_v = 1'b1;
    kw_ready_v = 1'b1;
    step();
    blk_valid_v = 1'b0;
    c1 = 0; c2 = 0; c8 = 0; cyc = 0;
    while ((c1 < 64 || c2 < 64 || c8 < 64) && cyc < 400) begin
      kw_ready_v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (kw_valid_1) begin
        chk("l1_round", 64'(round_1), 64'(c1));
        chk("l1_last", 64'(last_1), 64'(c1 == 63));
        chk("l1_kw", 64'(kw_1), 64'(ref_kw[0][c1]));
        if (kw_ready_v) c1 += 1;
      end
      if (kw_valid_2) begin
        chk("l2_round", 64'(round_2), 64'(c2));
        chk("l2_last", 64'(last_2), 64'(c2 == 62));
        for (int j = 0; j < 2; j++) chk("l2_kw", 64'(kw_2[j*32 +: 32]), 64'(ref_kw[0][c2+j]));
        if (kw_ready_v) c2 += 2;
      end
      if (kw_valid_8) begin
        chk("l8_round", 64'(round_8), 64'(c8));
        chk("l8_last", 64'(last_8), 64'(c8 == 56));
        for (int j = 0; j < 8; j++) chk("l8_kw", 64'(kw_8[j*32 +: 32]), 64'(ref_kw[0][c8+j]));
        if (kw_ready_v) c8 += 8;
      end
      step();
      cyc++;
    end
    kw_ready_v = 1'b0;
    chk("l1_words", 64'(c1), 64'd64);
    chk("l2_words", 64'(c2), 64'd64);
    chk("l8_words", 64'(c8), 64'd64);
    chk("lv_idle", 64'({kw_valid_1, kw_valid_2, kw_valid_8}), 64'd0);
  endtask

  initial begin
    logic [511:0] abc_blk, b1, b2;
    abc_blk = '0;
    abc_blk[31:0] = 32'h61626380;
    abc_blk[15*32 +: 32] = 32'h00000018;

    // 1. reset with a block offered throughout
    rst = 1'b1;
    w_in = abc_blk;
    blk_valid_a = 1'b1;
    repeat (3) step();
    chk("rst_valid", 64'(kw_valid_a), 64'd0);
    chk("rst_ready", 64'(blk_ready_a), 64'd1);
    chk("rst_round", 64'(round_a), 64'd0);
    chk("rst_last", 64'(last_a), 64'd0);
    chk("rst_kw", 64'(kw_a[63:0]), {KT[1], KT[0]});
    chk("rst_kw_hi", 64'(kw_a[127:64]), {KT[3], KT[2]});
    rst = 1'b0;
    blk_valid_a = 1'b0;
    step();
    chk("rst_no_load", 64'(kw_valid_a), 64'd0);

    // 2. "abc" block, full throughput
    run_a(abc_blk, 1'b0, 1'b1, -1);
    // 3. "abc" block under random backpressure, then random blocks
    run_a(abc_blk, 1'b1, 1'b1, -1);
    for (int n = 0; n < 3; n++) run_a(rand_block(), 1'b1, 1'b0, -1);

    // 4. other lane widths
    run_variants(abc_blk, 1'b0);
    run_variants(rand_block(), 1'b1);

    // 5. pipelined reload: second block follows with no idle cycle
    b1 = rand_block();
    b2 = rand_block();
    make_ref(b1, 0);
    make_ref(b2, 1);
    w_in = b1;
    blk_valid_p = 1'b1;
    kw_ready_p = 1'b1;
    step();
    blk_valid_p = 1'b0;
    for (int n = 0; n < 64; n += 4) begin
      chk("p1_valid", 64'(kw_valid_p), 64'd1);
      chk("p1_round", 64'(round_p), 64'(n));
      for (int j = 0; j < 4; j++) chk("p1_kw", 64'(kw_p[j*32 +: 32]), 64'(ref_kw[0][n+j]));
      if (n == 60) begin
        w_in = b2;
        blk_valid_p = 1'b1;
        #1;
        chk("p_ready_final", 64'(blk_ready_p), 64'd1);
      end else begin
        chk("p_ready_run", 64'(blk_ready_p), 64'd0);
      end
      step();
    end
    blk_valid_p = 1'b0;
    for (int n = 0; n < 64; n += 4) begin
      chk("p2_valid", 64'(kw_valid_p), 64'd1);
      chk("p2_round", 64'(round_p), 64'(n));
      chk("p2_last", 64'(last_p), 64'(n == 60));
      for (int j = 0; j < 4; j++) chk("p2_kw", 64'(kw_p[j*32 +: 32]), 64'(ref_kw[1][n+j]));
      step();
    end
    kw_ready_p = 1'b0;
    chk("p_end_valid", 64'(kw_valid_p), 64'd0);
    chk("p_end_ready", 64'(blk_ready_p), 64'd1);

    // 6. reset in the middle of a schedule
    run_a(rand_block(), 1'b0, 1'b0, 24);
    chk("mid_round", 64'(round_a), 64'd24);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(kw_valid_a), 64'd0);
    chk("mid_rst_round", 64'(round_a), 64'd0);
    chk("mid_rst_ready", 64'(blk_ready_a), 64'd1);
    step();
    rst = 1'b0;
    kw_ready_a = 1'b0;
    step();
    chk("mid_after_valid", 64'(kw_valid_a), 64'd0);
    run_a(rand_block(), 1'b1, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
